// File: rtl/cicero_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cicero_cmd_responder
//  Description : Device-side responder for the host command/status register
//                interface. Decodes cmd_register and executes memory
//                write/read, engine start, soft reset, elapsed-clock read and
//                FIFO-count read. Drives status_register / data_o_register
//                back to the host and the BRAM port-A / engine controls.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro:
//    CICERO_ELAPSED_CNT_EN  - REG_WIDTH saturating counter of cycles spent in
//                             RUNNING; without it READ_ELAPSED_CLOCK returns 0.
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    data_in_register           write data / FIFO selector
//    address_register           BRAM word address
//    start/end_cc_pointer_reg   string byte range for the engine (inclusive)
//    cmd_register               host command code
//    status_register            FSM state, zero-extended
//    data_o_register            read / report data
//    mem_addr/wdata/we/rdata    BRAM port A (1-cycle read latency)
//    engine_start/_ptrs         start pulse and latched pointers
//    engine_done/accept         engine completion and verdict
//    fifo_sel, fifo_count       FIFO selector and its peak occupancy
// ============================================================================
module cicero_cmd_responder #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_SEL_W = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_WIDTH-1:0]  data_in_register,
  input  logic [REG_WIDTH-1:0]  address_register,
  input  logic [REG_WIDTH-1:0]  start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]  end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]  cmd_register,
  output logic [REG_WIDTH-1:0]  status_register,
  output logic [REG_WIDTH-1:0]  data_o_register,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  engine_start,
  output logic [REG_WIDTH-1:0]  engine_start_ptr,
  output logic [REG_WIDTH-1:0]  engine_end_ptr,
  input  logic                  engine_done,
  input  logic                  engine_accept,
  output logic [FIFO_SEL_W-1:0] fifo_sel,
  input  logic [CNT_W-1:0]      fifo_count
);

  // Command codes (code 0 is NOP; any unlisted code behaves the same)
  localparam logic [REG_WIDTH-1:0] CMD_WRITE        = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_READ         = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_START        = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] CMD_RESET        = REG_WIDTH'(4);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED = REG_WIDTH'(5);
  localparam logic [REG_WIDTH-1:0] CMD_READ_FIFO    = REG_WIDTH'(6);

  // State encodings equal the host-visible status codes
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_ACCEPTED = 3'd2,
    ST_REJECTED = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [REG_WIDTH-1:0]   cmd_q;
  logic                   rd_pend;
  logic                   start_fire;
  logic [REG_WIDTH-1:0]   elapsed_val;

  logic is_write, is_read, is_start, is_reset, is_rd_elapsed, is_rd_fifo;
  logic start_rise;

  assign is_write      = (cmd_register == CMD_WRITE);
  assign is_read       = (cmd_register == CMD_READ);
  assign is_start      = (cmd_register == CMD_START);
  assign is_reset      = (cmd_register == CMD_RESET);
  assign is_rd_elapsed = (cmd_register == CMD_READ_ELAPSED);
  assign is_rd_fifo    = (cmd_register == CMD_READ_FIFO);

  // START is edge-detected so a host that leaves the command register at
  // START after completion never relaunches the engine.
  assign start_rise = is_start && (cmd_q != CMD_START);

  assign mem_addr        = address_register[ADDR_W-1:0];
  assign fifo_sel        = data_in_register[FIFO_SEL_W-1:0];
  assign status_register = {{(REG_WIDTH-3){1'b0}}, state};

  logic unused_addr_bits;
  assign unused_addr_bits = ^address_register[REG_WIDTH-1:ADDR_W];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_fire = 1'b0;
    if (is_reset) begin
      // Soft reset wins over a coincident engine_done and is the only exit
      // from ERROR. The engine itself keeps running.
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_RUNNING: begin
          if (engine_done) begin
            next_state = engine_accept ? ST_ACCEPTED : ST_REJECTED;
          end
        end
        ST_IDLE, ST_ACCEPTED, ST_REJECTED: begin
          if (start_rise) begin
            if (start_cc_pointer_register > end_cc_pointer_register) begin
              next_state = ST_ERROR;
            end else begin
              next_state = ST_RUNNING;
              start_fire = 1'b1;
            end
          end
        end
        default: begin
          next_state = state;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Command history, BRAM write port, engine launch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q            <= '0;
      mem_we           <= 1'b0;
      mem_wdata        <= '0;
      engine_start     <= 1'b0;
      engine_start_ptr <= '0;
      engine_end_ptr   <= '0;
    end else begin
      cmd_q        <= cmd_register;
      engine_start <= start_fire;
      // Writes are refused while the engine owns the BRAM contents.
      if (is_write && (state != ST_RUNNING)) begin
        mem_we    <= 1'b1;
        mem_wdata <= data_in_register;
      end else begin
        mem_we    <= 1'b0;
      end
      if (start_fire) begin
        engine_start_ptr <= start_cc_pointer_register;
        engine_end_ptr   <= end_cc_pointer_register;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path: BRAM read takes one extra edge through rd_pend; counter and
  // FIFO reads are captured directly on the sampling edge and take priority
  // over a capture completing on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend         <= 1'b0;
      data_o_register <= '0;
    end else begin
      rd_pend <= is_read;
      if (is_rd_elapsed) begin
        data_o_register <= elapsed_val;
      end else if (is_rd_fifo) begin
        data_o_register <= {{(REG_WIDTH-CNT_W){1'b0}}, fifo_count};
      end else if (rd_pend && !is_reset) begin
        // A soft reset discards the in-flight read.
        data_o_register <= mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Elapsed-clock counter
  // --------------------------------------------------------------------------
`ifdef CICERO_ELAPSED_CNT_EN
  localparam logic [REG_WIDTH-1:0] CNT_ONE = REG_WIDTH'(1);
  logic [REG_WIDTH-1:0] elapsed_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed_cnt <= '0;
    end else if (is_reset || start_fire) begin
      elapsed_cnt <= '0;
    end else if ((state == ST_RUNNING) && (elapsed_cnt != '1)) begin
      // Saturate rather than wrap so a runaway job still reads as "long".
      elapsed_cnt <= elapsed_cnt + CNT_ONE;
    end
  end

  assign elapsed_val = elapsed_cnt;
`else
  assign elapsed_val = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cicero_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cicero_cmd_responder
//  Description : Self-checking bench for cicero_cmd_responder. Directed
//                scenario tasks followed by a randomized command stream
//                checked against a behavioural host-visible model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cicero_cmd_responder;

  localparam int RW = 32;
  localparam int AW = 10;
  localparam int SW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] data_in_register;
  logic [RW-1:0] address_register;
  logic [RW-1:0] start_cc_pointer_register;
  logic [RW-1:0] end_cc_pointer_register;
  logic [RW-1:0] cmd_register;
  logic [RW-1:0] status_register;
  logic [RW-1:0] data_o_register;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_wdata;
  logic          mem_we;
  logic [RW-1:0] mem_rdata;
  logic          engine_start;
  logic [RW-1:0] engine_start_ptr;
  logic [RW-1:0] engine_end_ptr;
  logic          engine_done;
  logic          engine_accept;
  logic [SW-1:0] fifo_sel;
  logic [CW-1:0] fifo_count;

  int tests  = 0;
  int errors = 0;

  cicero_cmd_responder #(
    .REG_WIDTH(RW), .ADDR_W(AW), .FIFO_SEL_W(SW), .CNT_W(CW)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .data_in_register          (data_in_register),
    .address_register          (address_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .cmd_register              (cmd_register),
    .status_register           (status_register),
    .data_o_register           (data_o_register),
    .mem_addr                  (mem_addr),
    .mem_wdata                 (mem_wdata),
    .mem_we                    (mem_we),
    .mem_rdata                 (mem_rdata),
    .engine_start              (engine_start),
    .engine_start_ptr          (engine_start_ptr),
    .engine_end_ptr            (engine_end_ptr),
    .engine_done               (engine_done),
    .engine_accept             (engine_accept),
    .fifo_sel                  (fifo_sel),
    .fifo_count                (fifo_count)
  );

  always #5 clk = ~clk;

  // BRAM stand-in: the registered write data belongs to the address that
  // was presented on the cycle the WRITE command was sampled.
  logic [RW-1:0] bram [0:(1<<AW)-1];
  logic [AW-1:0] addr_d;
  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
    mem_rdata = '0;
    addr_d    = '0;
  end
  always @(posedge clk) begin
    if (mem_we) bram[addr_d] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
    addr_d    <= mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_register              = 0;
    data_in_register          = 0;
    address_register          = 0;
    start_cc_pointer_register = 0;
    end_cc_pointer_register   = 0;
    engine_done               = 0;
    engine_accept             = 0;
    fifo_count                = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [RW-1:0] expected_elapsed(input logic [RW-1:0] cycles);
`ifdef CICERO_ELAPSED_CNT_EN
    return cycles;
`else
    return '0;
`endif
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (status_register !== 0 || data_o_register !== 0 || mem_we !== 0 ||
        engine_start !== 0 || engine_start_ptr !== 0 || engine_end_ptr !== 0) begin
      errors++;
      $display("FAIL reset_values: status=%0d data_o=%0h we=%0b start=%0b sp=%0h ep=%0h, required all 0",
               status_register, data_o_register, mem_we, engine_start, engine_start_ptr, engine_end_ptr);
    end
    // Asynchronous reset while RUNNING, checked with no clock edge in between
    start_cc_pointer_register = 32'h10;
    end_cc_pointer_register   = 32'h1F;
    cmd_register              = 3;
    tick();
    tests++;
    if (status_register !== 1 || engine_start !== 1) begin
      errors++;
      $display("FAIL async_reset_setup: status=%0d start=%0b, required 1/1", status_register, engine_start);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (status_register !== 0 || engine_start !== 0 || mem_we !== 0) begin
      errors++;
      $display("FAIL async_reset: status=%0d start=%0b we=%0b, required 0/0/0",
               status_register, engine_start, mem_we);
    end
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_write_read();
    int we_cycles = 0;
    cmd_register = 1;
    for (int i = 0; i < 4; i++) begin
      address_register = i;
      data_in_register = 32'hA0 + i;
      tick();
      tests++;
      if (mem_we !== 1 || mem_wdata !== 32'hA0 + i) begin
        errors++;
        $display("FAIL write_stream[%0d]: we=%0b wdata=%0h, required 1/%0h", i, mem_we, mem_wdata, 32'hA0 + i);
      end
      if (mem_we === 1) we_cycles++;
    end
    cmd_register = 0;
    tick();
    if (mem_we === 1) we_cycles++;
    tests++;
    if (we_cycles !== 4) begin
      errors++;
      $display("FAIL write_we_cycles: observed %0d, required 4", we_cycles);
    end
    cmd_register     = 2;
    address_register = 2;
    tick();
    cmd_register = 0;
    tick();
    tests++;
    if (data_o_register !== 32'hA2) begin
      errors++;
      $display("FAIL read_addr2: data_o=%0h, required a2", data_o_register);
    end
    tick();
    tests++;
    if (data_o_register !== 32'hA2) begin
      errors++;
      $display("FAIL read_hold: data_o=%0h, required a2", data_o_register);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_start_accept();
    int pulses = 0;
    start_cc_pointer_register = 32'h10;
    end_cc_pointer_register   = 32'h1F;
    cmd_register              = 3;
    tick();
    if (engine_start === 1) pulses++;
    tests++;
    if (status_register !== 1 || engine_start_ptr !== 32'h10 || engine_end_ptr !== 32'h1F) begin
      errors++;
      $display("FAIL start_running: status=%0d sp=%0h ep=%0h, required 1/10/1f",
               status_register, engine_start_ptr, engine_end_ptr);
    end
    cmd_register = 0;
    for (int i = 1; i < 7; i++) begin
      tick();
      if (engine_start === 1) pulses++;
    end
    engine_done   = 1;
    engine_accept = 1;
    tick();
    if (engine_start === 1) pulses++;
    engine_done   = 0;
    engine_accept = 0;
    tests++;
    if (status_register !== 2 || pulses !== 1) begin
      errors++;
      $display("FAIL start_accept: status=%0d pulses=%0d, required 2/1", status_register, pulses);
    end
    cmd_register = 5;
    tick();
    cmd_register = 0;
    tests++;
    if (data_o_register !== expected_elapsed(7)) begin
      errors++;
      $display("FAIL elapsed_read: data_o=%0d, required %0d", data_o_register, expected_elapsed(7));
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_bad_pointers();
    start_cc_pointer_register = 32'h20;
    end_cc_pointer_register   = 32'h1F;
    cmd_register              = 3;
    tick();
    tests++;
    if (status_register !== 4 || engine_start !== 0) begin
      errors++;
      $display("FAIL bad_ptr: status=%0d start=%0b, required 4/0", status_register, engine_start);
    end
    cmd_register = 0;
    tick();
    start_cc_pointer_register = 32'h10;
    cmd_register              = 3;
    tick();
    tests++;
    if (status_register !== 4 || engine_start !== 0) begin
      errors++;
      $display("FAIL error_sticky: status=%0d start=%0b, required 4/0", status_register, engine_start);
    end
    cmd_register = 4;
    tick();
    cmd_register = 0;
    tests++;
    if (status_register !== 0) begin
      errors++;
      $display("FAIL reset_cmd: status=%0d, required 0", status_register);
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_write_during_run();
    int pulses = 0;
    start_cc_pointer_register = 32'h5;
    end_cc_pointer_register   = 32'h5;
    cmd_register              = 3;
    tick();
    cmd_register     = 1;
    data_in_register = 32'hDEAD;
    address_register = 7;
    tick();
    tests++;
    if (mem_we !== 0 || status_register !== 1) begin
      errors++;
      $display("FAIL write_in_run: we=%0b status=%0d, required 0/1", mem_we, status_register);
    end
    cmd_register  = 3;
    engine_done   = 1;
    engine_accept = 0;
    tick();
    if (engine_start === 1) pulses++;
    engine_done = 0;
    tests++;
    if (status_register !== 3) begin
      errors++;
      $display("FAIL reject: status=%0d, required 3", status_register);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (engine_start === 1) pulses++;
    end
    tests++;
    if (pulses !== 0 || status_register !== 3) begin
      errors++;
      $display("FAIL start_held: pulses=%0d status=%0d, required 0/3", pulses, status_register);
    end
    cmd_register = 0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fifo_count();
    data_in_register = 2;
    fifo_count       = 16'h35;
    cmd_register     = 6;
    #1;
    tests++;
    if (fifo_sel !== 2) begin
      errors++;
      $display("FAIL fifo_sel: observed %0d, required 2", fifo_sel);
    end
    tick();
    cmd_register = 0;
    tests++;
    if (data_o_register !== 32'h35) begin
      errors++;
      $display("FAIL fifo_count_read: data_o=%0h, required 35", data_o_register);
    end
  endtask

  // --------------------------------------------------------------------------
  // Random command stream. The model tracks what the host can observe:
  // job status, whether a read is awaiting its BRAM word, the RUNNING cycle
  // count, and the values that should appear on each output after each edge.
  // --------------------------------------------------------------------------
  task automatic test_random();
    int            status_m;
    int            prev_cmd;
    bit            read_waiting;
    logic [RW-1:0] run_cycles;
    logic [RW-1:0] data_m, sp_m, ep_m, wdata_m;
    bit            we_m, pulse_m;
    int            cmd, r;

    do_reset();
    status_m = 0; prev_cmd = 0; read_waiting = 0;
    run_cycles = 0; data_m = 0; sp_m = 0; ep_m = 0; wdata_m = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    cmd = 0;
        2:       cmd = 1;
        3:       cmd = 2;
        4, 5:    cmd = 3;
        6:       cmd = 4;
        7:       cmd = 5;
        8:       cmd = 6;
        default: cmd = 7 + $urandom_range(0, 50);
      endcase
      cmd_register              = cmd;
      data_in_register          = $urandom;
      address_register          = $urandom;
      start_cc_pointer_register = $urandom_range(0, 63);
      end_cc_pointer_register   = $urandom_range(0, 63);
      engine_done               = ($urandom_range(0, 5) == 0);
      engine_accept             = $urandom_range(0, 1);
      fifo_count                = $urandom;
      #1;
      tests++;
      if (mem_addr !== address_register[AW-1:0] || fifo_sel !== data_in_register[SW-1:0]) begin
        errors++;
        $display("FAIL rnd_comb[%0d]: addr=%0h sel=%0d, required %0h/%0d", cyc, mem_addr, fifo_sel,
                 address_register[AW-1:0], data_in_register[SW-1:0]);
      end

      // Expected effect of this edge
      we_m    = (cmd == 1) && (status_m != 1);
      if (we_m) wdata_m = data_in_register;
      pulse_m = 0;
      if (cmd == 5)      data_m = expected_elapsed(run_cycles);
      else if (cmd == 6) data_m = {16'h0, fifo_count};
      else if (read_waiting && cmd != 4) data_m = mem_rdata;

      if (cmd == 4) begin
        status_m   = 0;
        run_cycles = 0;
      end else if (status_m == 1) begin
        if (run_cycles != '1) run_cycles = run_cycles + 1;
        if (engine_done) status_m = engine_accept ? 2 : 3;
      end else if (status_m != 4 && cmd == 3 && prev_cmd != 3) begin
        if (start_cc_pointer_register > end_cc_pointer_register) begin
          status_m = 4;
        end else begin
          status_m   = 1;
          pulse_m    = 1;
          run_cycles = 0;
          sp_m       = start_cc_pointer_register;
          ep_m       = end_cc_pointer_register;
        end
      end
      read_waiting = (cmd == 2);
      prev_cmd     = cmd;

      tick();
      tests++;
      if (status_register !== status_m || engine_start !== pulse_m) begin
        errors++;
        $display("FAIL rnd_status[%0d]: status=%0d start=%0b, required %0d/%0b",
                 cyc, status_register, engine_start, status_m, pulse_m);
      end
      tests++;
      if (mem_we !== we_m || (we_m && mem_wdata !== wdata_m)) begin
        errors++;
        $display("FAIL rnd_write[%0d]: we=%0b wdata=%0h, required %0b/%0h", cyc, mem_we, mem_wdata, we_m, wdata_m);
      end
      tests++;
      if (data_o_register !== data_m) begin
        errors++;
        $display("FAIL rnd_data_o[%0d]: data_o=%0h, required %0h", cyc, data_o_register, data_m);
      end
      tests++;
      if (engine_start_ptr !== sp_m || engine_end_ptr !== ep_m) begin
        errors++;
        $display("FAIL rnd_ptrs[%0d]: sp=%0h ep=%0h, required %0h/%0h",
                 cyc, engine_start_ptr, engine_end_ptr, sp_m, ep_m);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_start_accept();
    test_bad_pointers();
    test_write_during_run();
    test_fifo_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
